regfile_2r1w_sb: RTL and testbench

//  MIPS integer register file: 32 x 32-bit, two combinational read ports, one

---
 rtl/mips_pkg.sv | 15 +
 rtl/decoder5to32.sv | 18 +
 rtl/regfile_2r1w_sb.sv | 89 ++++++++
 tb/tb_regfile_2r1w_sb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS register-file widths, well-known register numbers and word/address types.
// No logic; zero latency; no flow control.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/decoder5to32.sv
// Address to one-hot register select, with $0 never selected.
// Combinational, 0 cycles; no backpressure.
module decoder5to32
  import mips_pkg::*;
(
  input  logic             en_i,
  input  reg_addr_t        addr_i,
  output logic [NREGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i && (addr_i != REG_ZERO)) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// 32x32 register file: 2 combinational reads with write-through bypass, 1 write, pending-write scoreboard.
// Reads 0 cycles, writes and scoreboard update at the edge; never blocks, stall is advisory to the issuer.
module regfile_2r1w_sb
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  output word_t     rd1,
  output word_t     rd2,
  input  logic      we,
  input  reg_addr_t wa,
  input  word_t     wd,
  input  logic      iss_vld,
  input  reg_addr_t iss_addr,
  output logic      hz1,
  output logic      hz2,
  output logic      stall
);

  word_t            regs_q [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic [NREGS-1:0] wr_oh;
  logic [NREGS-1:0] iss_oh;
  logic             byp1;
  logic             byp2;

  decoder5to32 u_wr_dec (
    .en_i     (we),
    .addr_i   (wa),
    .onehot_o (wr_oh)
  );

  decoder5to32 u_iss_dec (
    .en_i     (iss_vld),
    .addr_i   (iss_addr),
    .onehot_o (iss_oh)
  );

  // Both decoders zero bit 0, so regs_q[0] and pend_q[0] hold their reset value forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_oh[i]) begin
          regs_q[i] <= wd;
        end
      end
    end
  end

  // Issue set is applied after retire clear so a same-cycle re-issue stays pending.
  always_comb begin
    pend_d = (pend_q & ~wr_oh) | iss_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    byp1 = we && (wa == ra1);
    byp2 = we && (wa == ra2);

    rd1 = '0;
    if (ra1 != REG_ZERO) begin
      rd1 = byp1 ? wd : regs_q[ra1];
    end

    rd2 = '0;
    if (ra2 != REG_ZERO) begin
      rd2 = byp2 ? wd : regs_q[ra2];
    end

    hz1   = pend_q[ra1] && !byp1;
    hz2   = pend_q[ra2] && !byp2;
    stall = hz1 || hz2;
  end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Randomized and directed bench for regfile_2r1w_sb against an array-based reference model.
module tb_regfile_2r1w_sb;
  import mips_pkg::*;

  logic      clk;
  logic      rst_n;
  reg_addr_t ra1, ra2, wa, iss_addr;
  word_t     rd1, rd2, wd;
  logic      we, iss_vld;
  logic      hz1, hz2, stall;

  word_t m_regs [32];
  bit    m_pend [32];
  int    checks;
  int    errors;

  regfile_2r1w_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_vld  (iss_vld),
    .iss_addr (iss_addr),
    .hz1      (hz1),
    .hz2      (hz2),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic word_t exp_rd(input reg_addr_t a);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_hz(input reg_addr_t a);
    if (a == 0) return 1'b0;
    return m_pend[a] && !(we && wa == a);
  endfunction

  function automatic reg_addr_t rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return '0;
    if (sel < 8) return reg_addr_t'($urandom_range(1, 7));
    return reg_addr_t'($urandom_range(0, 31));
  endfunction

  // One rising edge; the model sees the same inputs the DUT samples.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (iss_vld && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; wa = '0; wd = '0; iss_vld = 0; iss_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 1; i < 6; i++) begin
      we = 1; wa = reg_addr_t'(i); wd = $urandom; iss_vld = 1; iss_addr = reg_addr_t'(i + 10);
      step();
    end
    // Reset lands mid-cycle with a write and an issue in flight; both must be discarded.
    #2;
    we = 1; wa = 5'd3; wd = 32'hFFFF_0003; iss_vld = 1; iss_addr = 5'd3;
    rst_n = 0;
    model_clear();
    @(posedge clk);
    #1;
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      ra1 = reg_addr_t'(i); ra2 = reg_addr_t'(31 - i);
      #0.1;
      checks++;
      if (rd1 !== '0 || rd2 !== '0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_clear addr %0d: rd1=%h rd2=%h stall=%b, required 0/0/0", i, rd1, rd2, stall);
      end
    end
    rst_n = 1;
    step();
    ra1 = 5'd3; ra2 = 5'd13;
    #1;
    checks++;
    if (rd1 !== '0 || hz1 !== 1'b0 || hz2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: rd1=%h hz1=%b hz2=%b, required 0/0/0", rd1, hz1, hz2);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    we = 1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    step();
    idle_inputs(); ra1 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_read: rd1=%h, required %h", rd1, 32'hDEAD_BEEF);
    end
    we = 1; wa = 5'd0; wd = 32'h1234;
    step();
    idle_inputs(); ra2 = 5'd0;
    #1;
    checks++;
    if (rd2 !== '0) begin
      errors++;
      $display("FAIL write_zero: rd2=%h, required 0", rd2);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 1; wa = 5'd7; wd = 32'h1;
    step();
    we = 1; wa = 5'd7; wd = 32'hA5A5_A5A5; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    checks++;
    if (rd1 !== 32'hA5A5_A5A5 || rd2 !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL bypass: rd1=%h rd2=%h, required %h", rd1, rd2, 32'hA5A5_A5A5);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    iss_vld = 1; iss_addr = 5'd9;
    step();
    idle_inputs(); ra1 = 5'd9; ra2 = 5'd0;
    #1;
    checks++;
    if (hz1 !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL sb_pending: hz1=%b stall=%b, required 1/1", hz1, stall);
    end
    we = 1; wa = 5'd9; wd = 32'h0909_0909;
    #1;
    checks++;
    if (hz1 !== 1'b0 || stall !== 1'b0 || rd1 !== 32'h0909_0909) begin
      errors++;
      $display("FAIL sb_wb_bypass: hz1=%b stall=%b rd1=%h, required 0/0/09090909", hz1, stall, rd1);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (hz1 !== 1'b0 || rd1 !== 32'h0909_0909) begin
      errors++;
      $display("FAIL sb_cleared: hz1=%b rd1=%h, required 0/09090909", hz1, rd1);
    end
  endtask

  task automatic test_set_wins();
    idle_inputs();
    iss_vld = 1; iss_addr = 5'd12;
    step();
    iss_vld = 1; iss_addr = 5'd12; we = 1; wa = 5'd12; wd = 32'hC0DE_0012;
    step();
    idle_inputs(); ra1 = 5'd12; ra2 = 5'd12;
    #1;
    checks++;
    if (hz1 !== 1'b1 || hz2 !== 1'b1 || rd1 !== 32'hC0DE_0012) begin
      errors++;
      $display("FAIL set_wins: hz1=%b hz2=%b rd1=%h, required 1/1/c0de0012", hz1, hz2, rd1);
    end
    we = 1; wa = 5'd12; wd = 32'hC0DE_0013;
    step();
    idle_inputs();
  endtask

  task automatic test_zero_issue();
    idle_inputs();
    iss_vld = 1; iss_addr = 5'd0;
    step();
    idle_inputs(); ra1 = 5'd0; ra2 = 5'd0;
    #1;
    checks++;
    if (hz1 !== 1'b0 || rd1 !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_issue: hz1=%b rd1=%h stall=%b, required 0/0/0", hz1, rd1, stall);
    end
  endtask

  task automatic test_random();
    word_t e1, e2;
    logic  h1, h2;
    for (int n = 0; n < 500; n++) begin
      we       = ($urandom_range(0, 1) == 1);
      wa       = rand_addr();
      wd       = $urandom;
      iss_vld  = ($urandom_range(0, 2) == 0);
      iss_addr = rand_addr();
      ra1      = rand_addr();
      ra2      = ($urandom_range(0, 4) == 0) ? ra1 : rand_addr();
      #1;
      e1 = exp_rd(ra1); e2 = exp_rd(ra2);
      h1 = exp_hz(ra1); h2 = exp_hz(ra2);
      checks++;
      if (rd1 !== e1) begin
        errors++;
        $display("FAIL rand_rd1 iter %0d ra1=%0d: got %h, required %h", n, ra1, rd1, e1);
      end
      checks++;
      if (rd2 !== e2) begin
        errors++;
        $display("FAIL rand_rd2 iter %0d ra2=%0d: got %h, required %h", n, ra2, rd2, e2);
      end
      checks++;
      if (hz1 !== h1 || hz2 !== h2 || stall !== (h1 | h2)) begin
        errors++;
        $display("FAIL rand_hz iter %0d: hz1=%b hz2=%b stall=%b, required %b/%b/%b",
                 n, hz1, hz2, stall, h1, h2, h1 | h2);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    ra1 = '0; ra2 = '0;
    idle_inputs();
    model_clear();
    #2;
    ra1 = 5'd5; ra2 = 5'd31;
    #1;
    checks++;
    if (rd1 !== '0 || rd2 !== '0 || hz1 !== 1'b0 || hz2 !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL initial_reset: rd1=%h rd2=%h hz1=%b hz2=%b stall=%b, required all 0",
               rd1, rd2, hz1, hz2, stall);
    end
    #9;
    rst_n = 1;

    test_write_read();
    test_bypass();
    test_scoreboard();
    test_set_wins();
    test_zero_issue();
    test_random();
    test_reset();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
